// File: rtl/reg_link_pkg.sv
// Shared definitions for the 4-bit register serial link (transmit and receive sides).
package reg_link_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: tick is high on the last cycle of each CLKS_PER_BIT period.
module bit_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic restart,
  output logic tick,
  output logic tick_next_c
);

  localparam int unsigned DW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [DW-1:0] LAST = DW'(CLKS_PER_BIT - 1);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // restart forces count 0 for the first cycle of a newly entered state
  always_comb begin
    cnt_d = cnt_q + DW'(1);
    if (restart || tick_q) begin
      cnt_d = '0;
    end
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick        = tick_q;
  assign tick_next_c = tick_d;

endmodule

// File: rtl/reg_piso_tx.sv
// Framed PISO transmitter: start bit, LSB-first data, optional even parity, stop bit.
module reg_piso_tx
  import reg_link_pkg::*;
#(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Reg_In,
  input  logic             Load_Valid,
  output logic             Load_Ready,
  output logic             Ser_Out,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             par_q, par_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             tick, tick_next_c, restart_c;

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .Clock      (Clock),
    .Reset      (Reset),
    .restart    (restart_c),
    .tick       (tick),
    .tick_next_c(tick_next_c)
  );

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;

    case (state_q)
      ST_IDLE: begin
        if (Load_Valid && ready_q) begin
          shreg_d   = Reg_In;
          par_d     = ^Reg_In;
          bit_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    restart_c = (state_d != state_q) || (state_d == ST_IDLE);

    // Outputs follow the state being entered so they line up with it
    case (state_d)
      ST_START:  ser_d = START_BIT;
      ST_DATA:   ser_d = shreg_d[0];
      ST_PARITY: ser_d = par_d;
      ST_STOP:   ser_d = STOP_BIT;
      default:   ser_d = LINE_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_STOP) && tick_next_c;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      ser_q     <= LINE_IDLE;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      ser_q     <= ser_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign Ser_Out    = ser_q;
  assign Busy       = busy_q;
  assign Load_Ready = ready_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_reg_piso_tx.sv
// Directed bench for reg_piso_tx: three parameterisations sharing one clock and reset.
module tb_reg_piso_tx;

  logic       clk;
  logic       rst_n;
  logic [3:0] rin [3];
  logic       lv  [3];
  logic       ser [3];
  logic       rdy [3];
  logic       bsy [3];
  logic       dn  [3];

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_piso_tx #(.WIDTH(4), .CLKS_PER_BIT(2), .PARITY_EN(1)) dut0 (
    .Clock(clk), .Reset(rst_n), .Reg_In(rin[0]), .Load_Valid(lv[0]),
    .Load_Ready(rdy[0]), .Ser_Out(ser[0]), .Busy(bsy[0]), .Done(dn[0]));

  reg_piso_tx #(.WIDTH(4), .CLKS_PER_BIT(2), .PARITY_EN(0)) dut1 (
    .Clock(clk), .Reset(rst_n), .Reg_In(rin[1]), .Load_Valid(lv[1]),
    .Load_Ready(rdy[1]), .Ser_Out(ser[1]), .Busy(bsy[1]), .Done(dn[1]));

  reg_piso_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut2 (
    .Clock(clk), .Reset(rst_n), .Reg_In(rin[2]), .Load_Valid(lv[2]),
    .Load_Ready(rdy[2]), .Ser_Out(ser[2]), .Busy(bsy[2]), .Done(dn[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [3:0] word);
    rin[sel] = word;
    lv[sel]  = 1'b1;
    step();
    lv[sel]  = 1'b0;
  endtask

  // Samples n consecutive cycles starting with the current one
  task automatic capture(input int sel, input int n, output logic [31:0] s,
                         output int bc, output int dp, output int dc);
    s = '0; bc = 0; dp = 0; dc = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      s[i] = ser[sel];
      if (bsy[sel]) bc++;
      if (dn[sel]) begin
        dc++;
        dp = i + 1;
      end
    end
  endtask

  task automatic frame_check(input string tag, input int sel, input int n,
                             input logic [31:0] exp_ser, input bit check_idle);
    logic [31:0] s;
    int bc, dp, dc;
    capture(sel, n, s, bc, dp, dc);
    chk({tag, "_ser"}, s, exp_ser);
    chk({tag, "_busy_len"}, 32'(bc), 32'(n));
    chk({tag, "_done_cnt"}, 32'(dc), 32'd1);
    chk({tag, "_done_pos"}, 32'(dp), 32'(n));
    if (check_idle) begin
      step();
      chk({tag, "_idle_ser"}, 32'(ser[sel]), 32'd1);
      chk({tag, "_idle_rdy"}, 32'(rdy[sel]), 32'd1);
      chk({tag, "_idle_busy"}, 32'(bsy[sel]), 32'd0);
      chk({tag, "_idle_done"}, 32'(dn[sel]), 32'd0);
    end
  endtask

  task automatic idle_check(input string tag, input int sel);
    chk({tag, "_ser"}, 32'(ser[sel]), 32'd1);
    chk({tag, "_rdy"}, 32'(rdy[sel]), 32'd1);
    chk({tag, "_busy"}, 32'(bsy[sel]), 32'd0);
    chk({tag, "_done"}, 32'(dn[sel]), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rin[k] = 4'h0;
      lv[k]  = 1'b0;
    end

    // 1: reset held three cycles, then released
    for (int c = 0; c < 3; c++) begin
      step();
      idle_check("rst_hold", 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      idle_check("rst_rel", 0);
    end
    idle_check("rst_np", 1);
    idle_check("rst_c1", 2);

    // 2: 1101 -> 0,1,0,1,1,par1,stop1 at 2 cycles per bit
    send(0, 4'b1101);
    frame_check("f1101", 0, 14, 32'h0000_3FCC, 1'b1);

    // 4: valid held high, Reg_In changed during frame 1
    rin[0] = 4'b1011;
    lv[0]  = 1'b1;
    step();
    rin[0] = 4'b0011;
    frame_check("b2b_a", 0, 14, 32'h0000_3F3C, 1'b1);
    step();
    lv[0] = 1'b0;
    frame_check("b2b_b", 0, 14, 32'h0000_303C, 1'b1);

    // 5: reset asserted during data bit 2 of 1011
    step();
    send(0, 4'b1011);
    repeat (6) step();
    chk("mid_d2_ser", 32'(ser[0]), 32'd0);
    chk("mid_d2_busy", 32'(bsy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    idle_check("mid_rst", 0);
    for (int c = 0; c < 2; c++) begin
      step();
      idle_check("mid_rst_hold", 0);
    end
    rst_n = 1'b1;
    step();
    idle_check("mid_rst_rel", 0);
    send(0, 4'b0011);
    frame_check("post_rst", 0, 14, 32'h0000_303C, 1'b1);

    // 3: no parity, 1001 -> 0,1,0,0,1,stop1
    send(1, 4'b1001);
    frame_check("np1001", 1, 12, 32'h0000_0F0C, 1'b1);

    // 6: one cycle per bit, 0000 -> 0,0,0,0,0,par0,stop1
    send(2, 4'b0000);
    frame_check("c1_0000", 2, 7, 32'h0000_0040, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
